// File: rtl/vend_msg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_msg_sequencer_if
// Brief    : Button request / message ROM address bundle for the sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface vend_msg_sequencer_if;
    logic       b0;
    logic       b1;
    logic       b2;
    logic       b3;
    logic [3:0] rom_addr;
    logic       busy;
    logic       done;
    logic [2:0] req_id;

    // Button/display side drives the requests and observes the sequencer.
    modport master (
        output b0, b1, b2, b3,
        input  rom_addr, busy, done, req_id
    );

    modport slave (
        input  b0, b1, b2, b3,
        output rom_addr, busy, done, req_id
    );
endinterface
`default_nettype wire

// File: rtl/vend_msg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_msg_sequencer
// Brief    : Edge-triggered, priority-arbitrated message ROM address stepper.
// Revision : 1.0  initial release
// ============================================================================
module vend_msg_sequencer #(
    parameter int         DWELL     = 4,
    parameter logic [3:0] IDLE_ADDR = 4'd13
) (
    input  logic                 clk,
    input  logic                 reset,
    vend_msg_sequencer_if.slave  bus
);
    localparam int             CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [3:0]     TOP_ADDR  = 4'd15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t           state;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       sync3;
    logic [3:0]       edges;
    logic [3:0]       rom_addr;
    logic [3:0]       end_reg;
    logic [CNT_W-1:0] dwell_cnt;
    logic             busy;
    logic             done;
    logic [2:0]       req_id;

    logic [3:0]       win_start;
    logic [3:0]       win_end;
    logic [2:0]       win_id;

    assign edges = sync2 & ~sync3;

    // Fixed priority b1 > b0 > b2 > b3 with each request's address range.
    always_comb begin
        win_start = 4'd0;
        win_end   = 4'd0;
        win_id    = 3'd0;
        if (edges[1]) begin
            win_start = 4'd5;  win_end = 4'd6;  win_id = 3'd2;
        end else if (edges[0]) begin
            win_start = 4'd2;  win_end = 4'd3;  win_id = 3'd1;
        end else if (edges[2]) begin
            win_start = 4'd8;  win_end = 4'd12; win_id = 3'd3;
        end else if (edges[3]) begin
            win_start = 4'd0;  win_end = 4'd0;  win_id = 3'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 4'd0;
            sync2     <= 4'd0;
            sync3     <= 4'd0;
            state     <= IDLE;
            rom_addr  <= IDLE_ADDR;
            end_reg   <= 4'd0;
            dwell_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_id    <= 3'd0;
        end else begin
            sync1 <= {bus.b3, bus.b2, bus.b1, bus.b0};
            sync2 <= sync1;
            sync3 <= sync2;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|edges) begin
                        state     <= PLAY;
                        rom_addr  <= win_start;
                        end_reg   <= win_end;
                        req_id    <= win_id;
                        dwell_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                PLAY: begin
                    if (edges[3]) begin
                        // Cancel aborts silently and restarts on the b3 range.
                        rom_addr  <= 4'd0;
                        end_reg   <= 4'd0;
                        req_id    <= 3'd4;
                        dwell_cnt <= '0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        if (rom_addr == end_reg || rom_addr == TOP_ADDR) begin
                            state     <= IDLE;
                            rom_addr  <= IDLE_ADDR;
                            req_id    <= 3'd0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            dwell_cnt <= '0;
                        end else begin
                            rom_addr  <= rom_addr + 4'd1;
                            dwell_cnt <= '0;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr = rom_addr;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.req_id   = req_id;
endmodule
`default_nettype wire

// File: tb/tb_vend_msg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_msg_sequencer
// Brief    : Self-checking bench: message-schedule model plus directed pins.
// Revision : 1.0  initial release
// ============================================================================
module tb_vend_msg_sequencer;
    localparam int         DWELL     = 4;
    localparam logic [3:0] IDLE_ADDR = 4'd13;

    typedef struct packed {
        logic [3:0] addr;
        logic       busy;
        logic       done;
        logic [2:0] id;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btns = 4'd0;
    int         checks = 0;
    int         failures = 0;
    bit         started = 1'b0;

    vend_msg_sequencer_if bus();
    assign bus.b0 = btns[0];
    assign bus.b1 = btns[1];
    assign bus.b2 = btns[2];
    assign bus.b3 = btns[3];

    vend_msg_sequencer #(.DWELL(DWELL), .IDLE_ADDR(IDLE_ADDR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: each accepted request becomes a queue of per-cycle outputs.
    out_t       cur;
    out_t       sched[$];
    logic [3:0] h1, h2, h3, e;
    int         range_lo [1:4] = '{2, 5, 8, 0};
    int         range_hi [1:4] = '{3, 6, 12, 0};

    function automatic out_t idle_out();
        out_t o;
        o.addr = IDLE_ADDR; o.busy = 1'b0; o.done = 1'b0; o.id = 3'd0;
        return o;
    endfunction

    function automatic int pick(input logic [3:0] ev);
        if (ev[1]) return 2;
        if (ev[0]) return 1;
        if (ev[2]) return 3;
        return 4;
    endfunction

    task automatic build(input int id);
        out_t o;
        sched.delete();
        for (int a = range_lo[id]; a <= range_hi[id]; a++) begin
            for (int d = 0; d < DWELL; d++) begin
                o.addr = 4'(a); o.busy = 1'b1; o.done = 1'b0; o.id = 3'(id);
                sched.push_back(o);
            end
        end
        o = idle_out();
        o.done = 1'b1;
        sched.push_back(o);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            h1 = 4'd0; h2 = 4'd0; h3 = 4'd0;
            sched.delete();
            cur = idle_out();
            started = 1'b1;
        end else begin
            e  = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = btns;
            if (!cur.busy && e != 4'd0) build(pick(e));
            else if (cur.busy && e[3]) build(4);
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = idle_out();
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (bus.rom_addr !== cur.addr || bus.busy !== cur.busy ||
                bus.done !== cur.done || bus.req_id !== cur.id) begin
                failures++;
                $display("FAIL model t=%0t: got addr=%0d busy=%b done=%b id=%0d expected addr=%0d busy=%b done=%b id=%0d",
                         $time, bus.rom_addr, bus.busy, bus.done, bus.req_id,
                         cur.addr, cur.busy, cur.done, cur.id);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        while (bus.rom_addr != 4'(a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_addr_%0d", a), int'(bus.rom_addr), a);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idle", int'(bus.busy), 0);
    endtask

    initial begin
        int cnt;
        // Reset for a few edges with buttons low.
        repeat (3) @(negedge clk);
        chk("reset_addr", int'(bus.rom_addr), 13);
        chk("reset_busy", int'(bus.busy), 0);
        reset = 1'b0;

        // b2 pulse: range 8..12, busy for 5*DWELL cycles, then one done.
        @(negedge clk);
        btns[2] = 1'b1;
        @(negedge clk); btns[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2_start_addr", int'(bus.rom_addr), 8);
        chk("b2_req_id", int'(bus.req_id), 3);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.busy) cnt++;
        end
        chk("b2_busy_cycles", cnt, 20);
        chk("b2_done_addr", int'(bus.rom_addr), 13);
        chk("b2_done_busy", int'(bus.busy), 0);

        // Simultaneous b0+b1: b1 wins.
        @(negedge clk);
        btns = 4'b0011;
        @(negedge clk); btns = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("prio_req_id", int'(bus.req_id), 2);
        chk("prio_addr", int'(bus.rom_addr), 5);
        wait_idle();

        // b3 cancel during b2 at address 10.
        @(negedge clk);
        btns[2] = 1'b1;
        @(negedge clk); btns[2] = 1'b0;
        wait_addr(10);
        btns[3] = 1'b1;
        @(negedge clk); btns[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("cancel_addr", int'(bus.rom_addr), 0);
        chk("cancel_req_id", int'(bus.req_id), 4);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("cancel_done_count", cnt, 1);

        // b1 raised during a b0 message is dropped; holding it never retriggers.
        btns[0] = 1'b1;
        @(negedge clk); btns[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b0_addr", int'(bus.rom_addr), 2);
        btns[1] = 1'b1;
        wait_idle();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy) cnt++;
        end
        chk("held_b1_no_retrigger", cnt, 0);
        btns[1] = 1'b0;
        @(negedge clk);

        // Reset mid-b2, b1 held through release starts a fresh message.
        btns[2] = 1'b1;
        @(negedge clk); btns[2] = 1'b0;
        wait_addr(9);
        reset = 1'b1;
        btns[1] = 1'b1;
        @(negedge clk);
        chk("midreset_addr", int'(bus.rom_addr), 13);
        chk("midreset_busy", int'(bus.busy), 0);
        chk("midreset_done", int'(bus.done), 0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("post_reset_addr", int'(bus.rom_addr), 5);
        chk("post_reset_req_id", int'(bus.req_id), 2);
        btns = 4'd0;
        wait_idle();

        // Random button toggling with rare resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) btns[b] = ~btns[b];
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        btns  = 4'd0;
        repeat (40) @(negedge clk);
        chk("final_idle_busy", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
